dekatron_step_driver: RTL and testbench
=======================================

// Module: dekatron_step_driver
// PURPOSE
//  Drives one dekatron-style 10-position ring counter to a requested BCD digit by
//  emitting discrete step pulses, tracking tube position as a one-hot vector.
//  Inverse of the one-hot/BCD decode path: it takes an 8-4-2-1 target and produces
//  the ring stepping that realises it. Sits between the digit sequencer and the
//  tube pulse drivers; Position/PositionBcd feed the readback decode path.
// PARAMETERS
//  PULSE_WIDTH  2  cycles each step pulse is held high (>=1)
//  GAP_WIDTH    1  cycles low between consecutive step pulses (>=1)
// PORTS
//  Clk          in   1   system clock, all logic on rising edge
//  Rst          in   1   synchronous reset, active high
//  Req          in   1   request valid; TargetBcd sampled when Req & Ready
//  TargetBcd    in   4   requested digit, 8-4-2-1 BCD
//  Ready        out  1   block idle, able to accept Req
//  Busy         out  1   stepping in progress (accept cycle to Done, exclusive)
//  Done         out  1   one-cycle pulse: Position equals accepted target
//  Err          out  1   one-cycle pulse: accepted TargetBcd > 9, request dropped
//  StepFwd      out  1   forward step pulse to tube driver (pos n -> n+1, 9 -> 0)
//  StepBwd      out  1   backward step pulse to tube driver (pos n -> n-1, 0 -> 9)
//  Position     out  10  one-hot tube position, bit n = digit n
//  PositionBcd  out  4   BCD encoding of Position
// BEHAVIOUR
//  - Reset: Position=10'b0000000001, PositionBcd=0, Ready=1, Busy=0, Done=0,
//    Err=0, StepFwd=0, StepBwd=0, FSM=IDLE. Reset mid-stepping aborts at once.
//  - FSM states: IDLE, PULSE, GAP, DONE.
//  - IDLE (Ready=1): on Req at cycle T:
//      TargetBcd>9       -> Err=1 at T+1, stay IDLE, Ready stays 1, no steps.
//      target==Position  -> DONE at T+1 (no steps).
//      else              -> latch target and direction, PULSE at T+1.
//    Req without Ready is ignored; no queuing, TargetBcd changes while busy ignored.
//  - PULSE: selected StepFwd/StepBwd high for PULSE_WIDTH cycles; Position
//    rotates one place on the clock edge ending the last pulse cycle; PositionBcd
//    updates the same edge. Exactly one of StepFwd/StepBwd high, never both.
//  - GAP: both steps low GAP_WIDTH cycles; at end: Position==target -> DONE,
//    else -> PULSE.
//  - DONE: Done=1, Busy=0, Ready=0 for exactly one cycle, then IDLE.
//  - Latency: n steps -> Done asserted at T+1+n*(PULSE_WIDTH+GAP_WIDTH).
//  - Position is always exactly one-hot; wrap 9<->0 is a normal single step.
//  - Busy=1 in PULSE and GAP only. Err and Done never high together.
// CONFIGURATION
//  DEKATRON_SHORTEST_PATH_EN defined: direction chosen at accept; d=(target-pos)
//    mod 10; d<=5 -> forward, d>=6 -> backward (tie at 5 goes forward); steps =
//    min(d,10-d).
//  Not defined: always forward, d steps; StepBwd tied to 0.
// TESTING (PULSE_WIDTH=2, GAP_WIDTH=1)
//  1 Rst held 2 cycles -> Position=0x001, PositionBcd=0, Ready=1, all pulses 0.
//  2 From pos 0, Req TargetBcd=3 at T -> 3 StepFwd pulses of 2 cycles, 1-cycle
//    gaps; Position 0x002,0x004,0x008; Done at T+10, PositionBcd=3.
//  3 From pos 3, Req TargetBcd=3 -> Done at T+1, no step pulses; TargetBcd=12 ->
//    Err at T+1, Position unchanged, Ready remains 1.
//  4 From pos 9, Req TargetBcd=1 -> 2 StepFwd pulses, Position 0x001 then 0x002,
//    Done at T+7 (wrap check).
//  5 From pos 0, Req TargetBcd=8: with DEKATRON_SHORTEST_PATH_EN -> 2 StepBwd,
//    pos 9 then 8, Done at T+7; without -> 8 StepFwd, Done at T+25.
//  6 Req pulses during stepping ignored; Rst asserted mid-PULSE -> next cycle
//    Position=0x001, steps low, Ready=1, no Done emitted.

Source files
------------

// File: rtl/dekatron_step_driver.sv
// dekatron_step_driver
// Steps a 10-position dekatron ring to a requested BCD digit with discrete
// step pulses and tracks the tube position as a one-hot vector plus its BCD
// encoding.
//
// Optional feature macro: DEKATRON_SHORTEST_PATH_EN
//   defined     : direction chosen per request; forward when the forward
//                 distance is 0..5, backward when it is 6..9.
//   not defined : always steps forward; step_bwd_o is tied low.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | ready, waiting for req_i; bad digits answered with err_o
// ST_PULSE | selected step line held high for PULSE_WIDTH cycles
// ST_GAP   | both step lines low for GAP_WIDTH cycles, then re-check target
// ST_DONE  | one-cycle done_o, position equals the accepted target
module dekatron_step_driver #(
  parameter int unsigned PULSE_WIDTH = 2,
  parameter int unsigned GAP_WIDTH   = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_i,
  input  logic [3:0] target_bcd_i,
  output logic       ready_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output logic       step_fwd_o,
  output logic       step_bwd_o,
  output logic [9:0] position_o,
  output logic [3:0] position_bcd_o
);

  // The phase timer is shared by PULSE and GAP, so size it for the longer one.
  localparam int unsigned MAX_W = (PULSE_WIDTH > GAP_WIDTH) ? PULSE_WIDTH : GAP_WIDTH;
  localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_WIDTH - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       target_q;
  logic [9:0]       position_q;
  logic [3:0]       position_bcd_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic             step_fwd_q;

  logic [9:0]       position_d;
  logic [3:0]       position_bcd_d;

`ifdef DEKATRON_SHORTEST_PATH_EN
  logic             step_bwd_q;
  logic             dir_fwd_q;
  logic [3:0]       dist_d;
  logic             accept_fwd_d;

  // Forward distance (target - position) mod 10; ties at 5 go forward.
  always_comb begin
    if (target_bcd_i >= position_bcd_q) begin
      dist_d = target_bcd_i - position_bcd_q;
    end else begin
      dist_d = target_bcd_i + 4'd10 - position_bcd_q;
    end
    accept_fwd_d = (dist_d <= 4'd5);
  end
`endif

  // Position one step on in the latched direction, wrapping 9<->0.
  always_comb begin
    position_d     = {position_q[8:0], position_q[9]};
    position_bcd_d = (position_bcd_q == 4'd9) ? 4'd0 : position_bcd_q + 4'd1;
`ifdef DEKATRON_SHORTEST_PATH_EN
    if (!dir_fwd_q) begin
      position_d     = {position_q[0], position_q[9:1]};
      position_bcd_d = (position_bcd_q == 4'd0) ? 4'd9 : position_bcd_q - 4'd1;
    end
`endif
  end

  // Sequencing FSM with all outputs registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      target_q       <= 4'd0;
      position_q     <= 10'b00_0000_0001;
      position_bcd_q <= 4'd0;
      ready_q        <= 1'b1;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      step_fwd_q     <= 1'b0;
`ifdef DEKATRON_SHORTEST_PATH_EN
      step_bwd_q     <= 1'b0;
      dir_fwd_q      <= 1'b1;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_i) begin
            if (target_bcd_i > 4'd9) begin
              // Not a decimal digit: flag it and stay available.
              err_q <= 1'b1;
            end else if (target_bcd_i == position_bcd_q) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              ready_q <= 1'b0;
            end else begin
              state_q  <= ST_PULSE;
              target_q <= target_bcd_i;
              cnt_q    <= PULSE_LOAD;
              ready_q  <= 1'b0;
              busy_q   <= 1'b1;
`ifdef DEKATRON_SHORTEST_PATH_EN
              dir_fwd_q  <= accept_fwd_d;
              step_fwd_q <= accept_fwd_d;
              step_bwd_q <= ~accept_fwd_d;
`else
              step_fwd_q <= 1'b1;
`endif
            end
          end
        end

        ST_PULSE: begin
          if (cnt_q == '0) begin
            // The tube advances as the pulse ends.
            position_q     <= position_d;
            position_bcd_q <= position_bcd_d;
            step_fwd_q     <= 1'b0;
`ifdef DEKATRON_SHORTEST_PATH_EN
            step_bwd_q     <= 1'b0;
`endif
            cnt_q          <= GAP_LOAD;
            state_q        <= ST_GAP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        ST_GAP: begin
          if (cnt_q == '0) begin
            if (position_bcd_q == target_q) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= ST_PULSE;
              cnt_q   <= PULSE_LOAD;
`ifdef DEKATRON_SHORTEST_PATH_EN
              step_fwd_q <= dir_fwd_q;
              step_bwd_q <= ~dir_fwd_q;
`else
              step_fwd_q <= 1'b1;
`endif
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end

        default: begin
          state_q    <= ST_IDLE;
          ready_q    <= 1'b1;
          busy_q     <= 1'b0;
          step_fwd_q <= 1'b0;
`ifdef DEKATRON_SHORTEST_PATH_EN
          step_bwd_q <= 1'b0;
`endif
        end
      endcase
    end
  end

  assign ready_o        = ready_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign step_fwd_o     = step_fwd_q;
  assign position_o     = position_q;
  assign position_bcd_o = position_bcd_q;
`ifdef DEKATRON_SHORTEST_PATH_EN
  assign step_bwd_o     = step_bwd_q;
`else
  assign step_bwd_o     = 1'b0;
`endif

endmodule

// File: tb/tb_dekatron_step_driver.sv
// Randomized scoreboard bench for dekatron_step_driver.
module tb_dekatron_step_driver;
  localparam int PW  = 2;
  localparam int GW  = 1;
  localparam int PER = PW + GW;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic [3:0] tgt;
  logic       ready_o, busy_o, done_o, err_o, step_fwd_o, step_bwd_o;
  logic [9:0] position_o;
  logic [3:0] position_bcd_o;

  dekatron_step_driver #(.PULSE_WIDTH(PW), .GAP_WIDTH(GW)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .target_bcd_i(tgt),
    .ready_o(ready_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .step_fwd_o(step_fwd_o), .step_bwd_o(step_bwd_o),
    .position_o(position_o), .position_bcd_o(position_bcd_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit is_err;
    int cyc;
    int pos;
  } exp_t;
  exp_t sb_q[$];

  // Reference model: digit position plus the timeline of the last stepping job.
  int m_pos   = 0;
  int m_free  = 0;
  int m_T     = -1000;
  int m_D     = -1000;
  int m_n     = 0;
  int m_dir   = 1;
  int m_start = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit m_ready();
    return cyc >= m_free;
  endfunction

  task automatic model_accept(input int t);
    exp_t e;
    int T;
    T = cyc;
    if (t > 9) begin
      e.is_err = 1'b1;
      e.cyc    = T + 1;
      e.pos    = m_pos;
      m_free   = T + 1;
    end else begin
      int d;
      int n;
      int dir;
      d   = (t - m_pos + 10) % 10;
      n   = d;
      dir = 1;
`ifdef DEKATRON_SHORTEST_PATH_EN
      if (d > 5) begin
        n   = 10 - d;
        dir = -1;
      end
`endif
      m_T     = T;
      m_n     = n;
      m_dir   = dir;
      m_start = m_pos;
      m_D     = T + 1 + n * PER;
      m_pos   = t;
      m_free  = m_D + 1;
      e.is_err = 1'b0;
      e.cyc    = m_D;
      e.pos    = t;
    end
    sb_q.push_back(e);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    req = 1'b0;
    tgt = 4'($urandom_range(0, 15));
  endtask

  // Issue a request once the model says the block is ready; while waiting,
  // throw random req pulses at the busy DUT, which must ignore them.
  task automatic do_req(input int t);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      if (m_ready()) begin
        req = 1'b1;
        tgt = 4'(t);
        model_accept(t);
        acc = 1'b1;
      end else begin
        req = 1'($urandom_range(0, 1));
        tgt = 4'($urandom_range(0, 15));
      end
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL req_timeout cycle=%0d actual=not_accepted expected=accepted", cyc);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    req = 1'b0;
    sb_q.delete();
    repeat (n - 1) @(negedge clk);
    @(negedge clk);
    rst     = 1'b0;
    m_pos   = 0;
    m_start = 0;
    m_n     = 0;
    m_T     = -1000;
    m_D     = -1000;
    m_free  = cyc;
  endtask

  // Monitor: compares every cycle just after the active edge.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      check("rst_position", position_o, 10'h001);
      check("rst_bcd", position_bcd_o, 0);
      check("rst_ready", ready_o, 1);
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_err", err_o, 0);
      check("rst_step_fwd", step_fwd_o, 0);
      check("rst_step_bwd", step_bwd_o, 0);
    end else begin
      int comp;
      int ep;
      bit in_job;
      bit st;
      logic [9:0] oh;
      comp = 0;
      if (m_n > 0 && cyc >= m_T + 1 + PW) comp = (cyc - m_T - 1 - PW) / PER + 1;
      if (comp > m_n) comp = m_n;
      ep     = (((m_start + m_dir * comp) % 10) + 10) % 10;
      oh     = 10'b1 << ep;
      in_job = (m_n > 0) && (cyc > m_T) && (cyc < m_D);
      st     = in_job && (((cyc - m_T - 1) % PER) < PW);
      check("position", position_o, oh);
      check("position_bcd", position_bcd_o, ep);
      check("step_fwd", step_fwd_o, st && (m_dir == 1));
      check("step_bwd", step_bwd_o, st && (m_dir == -1));
      check("busy", busy_o, in_job);
      check("ready", ready_o, m_ready());
      check("done_err_exclusive", done_o & err_o, 0);
      while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
        exp_t m;
        m = sb_q.pop_front();
        check("missing_event_at_cycle", 0, m.cyc);
      end
      if (done_o || err_o) begin
        if (sb_q.size() == 0) begin
          check("unexpected_event", 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("event_is_err", err_o, e.is_err);
          check("event_cycle", cyc, e.cyc);
          check("event_bcd", position_bcd_o, e.pos);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    req = 1'b0;
    tgt = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    m_free = cyc;

    // Directed cases: 3 steps, same digit, bad digit, wrap 9->1, long way to 8.
    do_req(3);
    do_req(3);
    do_req(12);
    do_req(9);
    do_req(1);
    do_req(0);
    do_req(8);

    for (int k = 0; k < 250; k++) begin
      repeat ($urandom_range(0, 2)) idle_cycle();
      do_req($urandom_range(0, 15));
    end

    // Abort mid-pulse: no done may follow, and the tube restarts at digit 0.
    repeat (30) idle_cycle();
    do_req((m_pos + 4) % 10);
    do_reset(1);
    do_req(2);
    repeat (40) idle_cycle();
    check("scoreboard_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog cycle=%0d actual=running expected=finished", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
